// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port synchronous memory between the fetch and
//            data ports; data wins by default, fetch wins once starved.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [DATA_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic [3:0]            dm_mask,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_mask,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_IF   = 2'd1,
        R_DM   = 2'd2
    } resp_state_t;

    resp_state_t r_state;
    resp_state_t w_state_nxt;
    logic [3:0]  r_starve_cnt;
    logic        w_if_win;

    // Fetch only beats a concurrent data request once it has been starved.
    assign w_if_win = if_req & (~dm_req | (r_starve_cnt == c_STARVE_LIMIT));
    assign if_gnt   = w_if_win;
    assign dm_gnt   = dm_req & ~w_if_win;
    assign mem_en   = if_gnt | dm_gnt;
    assign mem_we   = dm_gnt & dm_we;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = 4'b0000;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            mem_mask  = dm_mask;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_starve_cnt <= 4'd0;
        end else if (~if_req | if_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != c_STARVE_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= R_NONE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The owner of the next cycle's read data is decided by this cycle's grant.
    always_comb begin
        w_state_nxt = R_NONE;
        if (if_gnt) begin
            w_state_nxt = R_IF;
        end else if (dm_gnt & ~dm_we) begin
            w_state_nxt = R_DM;
        end
    end

    assign if_rvalid = (r_state == R_IF);
    assign dm_rvalid = (r_state == R_DM);
    assign if_rdata  = (r_state == R_IF) ? mem_rdata : '0;
    assign dm_rdata  = (r_state == R_DM) ? mem_rdata : '0;

endmodule
`default_nettype wire
